// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a small transmit FIFO.
// Frames (start, data LSB first, optional parity, stop) go out back-to-back.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] timer;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 par_next;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;
    logic                 fifo_empty;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count < CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign bit_end    = (timer == '0);
    assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
    assign tx_busy    = (state != S_IDLE);
    assign par_next   = (PARITY == 1) ? ~^head : ^head;

    // A frame starts from IDLE or straight out of the final stop bit.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) ||
                  (state == S_STOP && bit_end && last_stop));

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            period   <= '0;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
        end else if (pop) begin
            // Divisor is captured here only, so mid-frame changes wait.
            shreg   <= head;
            par_bit <= par_next;
            period  <= baud_div;
            timer   <= baud_div;
            tx      <= 1'b0;
            state   <= S_START;
        end else begin
            case (state)
                S_START: begin
                    if (bit_end) begin
                        timer   <= period;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer <= period;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        timer    <= period;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            timer    <= period;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_IDLE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
